// File: rtl/freq_cnt_pkg.sv
// Shared types and default widths for the frequency-counter gate sequencer.
package freq_cnt_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  localparam int DEF_LOG2N_WIDTH = 5;
  localparam int DEF_N_WIDTH     = 32;
  localparam int DEF_COUNT_WIDTH = 32;
  localparam int EFF_MAX         = DEF_N_WIDTH - 1;

  // Largest exponent whose gate length still fits a gate counter of n_width bits.
  function automatic int eff_max(input int n_width);
    return n_width - 1;
  endfunction

endpackage

// File: rtl/pow2.sv
// Gate-length decoder: n = 1 << log2n.
module pow2
  import freq_cnt_pkg::*;
#(
  parameter int LOG2N_WIDTH = DEF_LOG2N_WIDTH,
  parameter int N_WIDTH     = DEF_N_WIDTH
) (
  input  logic [LOG2N_WIDTH-1:0] log2n,
  output logic [N_WIDTH-1:0]     n
);

  assign n = {{(N_WIDTH-1){1'b0}}, 1'b1} << log2n;

endmodule

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus edge flop; rise pulses one cycle per rising edge of d.
module sync_edge_det
  import freq_cnt_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise
);

  logic [2:0] sh_r;

  // Synchronizer chain; sh_r[2] holds the previous synchronized sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_r <= 3'b000;
    end else begin
      sh_r <= {sh_r[1:0], d};
    end
  end

  assign rise = sh_r[1] & ~sh_r[2];

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-time sequencer: back-to-back 2^eff-cycle windows counting rising edges of sig_in,
// publishing count, exponent and overflow at each window end.
module freq_gate_ctrl
  import freq_cnt_pkg::*;
#(
  parameter int LOG2N_WIDTH = DEF_LOG2N_WIDTH,
  parameter int N_WIDTH     = DEF_N_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic [LOG2N_WIDTH-1:0] log2N,
  input  logic                   sig_in,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic [LOG2N_WIDTH-1:0] log2N_o,
  output logic                   ovf_o,
  output logic                   valid_o
);

  localparam logic [31:0]            EFF_LIM = 32'(eff_max(N_WIDTH));
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  state_t                 state_r, state_s;
  logic [LOG2N_WIDTH-1:0] eff_s, log2n_r, log2n_s, log2n_o_r;
  logic [N_WIDTH-1:0]     n_s, gate_cnt_r, gate_cnt_s;
  logic [COUNT_WIDTH-1:0] edge_cnt_r, edge_cnt_s, edge_sum_s, count_r;
  logic                   ovf_r, ovf_s, ovf_o_r;
  logic                   rise_s, sat_hit_s, last_s, pub_s;
  logic                   busy_r, valid_r;

  sync_edge_det u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (sig_in),
    .rise (rise_s)
  );

  pow2 #(
    .LOG2N_WIDTH (LOG2N_WIDTH),
    .N_WIDTH     (N_WIDTH)
  ) u_pow2 (
    .log2n (log2n_r),
    .n     (n_s)
  );

  assign eff_s      = (32'(log2N) > EFF_LIM) ? LOG2N_WIDTH'(EFF_LIM) : log2N;
  assign last_s     = (gate_cnt_r == (n_s - {{(N_WIDTH-1){1'b0}}, 1'b1}));
  assign sat_hit_s  = rise_s & (edge_cnt_r == CNT_MAX);
  assign edge_sum_s = sat_hit_s ? edge_cnt_r
                                : edge_cnt_r + {{(COUNT_WIDTH-1){1'b0}}, rise_s};

  // Next-state and window-counter update; a window end with en high restarts in place.
  always_comb begin
    state_s    = state_r;
    log2n_s    = log2n_r;
    gate_cnt_s = gate_cnt_r;
    edge_cnt_s = edge_cnt_r;
    ovf_s      = ovf_r;
    pub_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s    = GATE;
          log2n_s    = eff_s;
          gate_cnt_s = {N_WIDTH{1'b0}};
          edge_cnt_s = {COUNT_WIDTH{1'b0}};
          ovf_s      = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      GATE: begin
        if (last_s) begin
          pub_s      = 1'b1;
          state_s    = en ? GATE : IDLE;
          log2n_s    = eff_s;
          gate_cnt_s = {N_WIDTH{1'b0}};
          edge_cnt_s = {COUNT_WIDTH{1'b0}};
          ovf_s      = 1'b0;
        end else if (!en) begin
          state_s = IDLE;
        end else begin
          gate_cnt_s = gate_cnt_r + {{(N_WIDTH-1){1'b0}}, 1'b1};
          edge_cnt_s = edge_sum_s;
          ovf_s      = ovf_r | sat_hit_s;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and window counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      log2n_r    <= {LOG2N_WIDTH{1'b0}};
      gate_cnt_r <= {N_WIDTH{1'b0}};
      edge_cnt_r <= {COUNT_WIDTH{1'b0}};
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      log2n_r    <= log2n_s;
      gate_cnt_r <= gate_cnt_s;
      edge_cnt_r <= edge_cnt_s;
      ovf_r      <= ovf_s;
    end
  end

  // Result registers; the last edge of the window is folded in at publication.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      count_r   <= {COUNT_WIDTH{1'b0}};
      log2n_o_r <= {LOG2N_WIDTH{1'b0}};
      ovf_o_r   <= 1'b0;
    end else begin
      busy_r  <= (state_s == GATE);
      valid_r <= pub_s;
      if (pub_s) begin
        count_r   <= edge_sum_s;
        log2n_o_r <= log2n_r;
        ovf_o_r   <= ovf_r | sat_hit_s;
      end
    end
  end

  assign busy    = busy_r;
  assign valid_o = valid_r;
  assign count_o = count_r;
  assign log2N_o = log2n_o_r;
  assign ovf_o   = ovf_o_r;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: default build, 4-bit counter build and 8-bit gate build.
module tb_freq_gate_ctrl;

  logic       clk;
  logic       rstn;
  logic       en, en_sat, en_clp;
  logic [4:0] log2n;
  logic       sig_in;

  logic        busy_m, valid_m, ovf_m;
  logic [31:0] count_m;
  logic [4:0]  l2_m;
  logic        busy_s, valid_s, ovf_s;
  logic [3:0]  count_s;
  logic [4:0]  l2_s;
  logic        busy_c, valid_c, ovf_c;
  logic [31:0] count_c;
  logic [4:0]  l2_c;

  int checks = 0;
  int errors = 0;
  int period = 0;
  int ph     = 0;

  freq_gate_ctrl dut (
    .clk (clk), .rstn (rstn), .en (en), .log2N (log2n), .sig_in (sig_in),
    .busy (busy_m), .count_o (count_m), .log2N_o (l2_m), .ovf_o (ovf_m), .valid_o (valid_m)
  );

  freq_gate_ctrl #(.COUNT_WIDTH (4)) u_sat (
    .clk (clk), .rstn (rstn), .en (en_sat), .log2N (log2n), .sig_in (sig_in),
    .busy (busy_s), .count_o (count_s), .log2N_o (l2_s), .ovf_o (ovf_s), .valid_o (valid_s)
  );

  freq_gate_ctrl #(.N_WIDTH (8)) u_clp (
    .clk (clk), .rstn (rstn), .en (en_clp), .log2N (log2n), .sig_in (sig_in),
    .busy (busy_c), .count_o (count_c), .log2N_o (l2_c), .ovf_o (ovf_c), .valid_o (valid_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square wave on sig_in, updated shortly after each rising clock edge.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ph = ph + 1;
      if (period == 0) sig_in = 1'b0;
      else             sig_in = ((ph % period) < (period / 2));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic vsel(input int w);
    case (w)
      0:       return valid_m;
      1:       return valid_s;
      default: return valid_c;
    endcase
  endfunction

  // Counts falling edges until the selected instance shows valid_o, bounded by limit.
  task automatic wait_valid(input string tag, input int w, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vsel(w) && n < limit);
    check(tag, 64'(vsel(w)), 64'd1);
  endtask

  initial begin
    int n;
    logic saw;
    logic [31:0] prev_cnt;
    logic [4:0]  prev_l2;
    logic [31:0] last;

    rstn = 1'b0; en = 1'b0; en_sat = 1'b0; en_clp = 1'b0; log2n = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_busy",  64'(busy_m),  64'd0);
    check("rst_count", 64'(count_m), 64'd0);
    check("rst_log2n", 64'(l2_m),    64'd0);
    check("rst_ovf",   64'(ovf_m),   64'd0);
    check("rst_valid", 64'(valid_m), 64'd0);
    rstn = 1'b1;

    // Periodic input, 1024-cycle windows, 128 edges each.
    period = 8; log2n = 5'd10;
    repeat (4) @(negedge clk);
    en = 1'b1;
    wait_valid("w10_first_to", 0, 3000, n);
    check("w10_first_lat",   64'(n), 64'd1025);
    check("w10_first_range", 64'(count_m >= 32'd127 && count_m <= 32'd129), 64'd1);
    check("w10_log2n",       64'(l2_m), 64'd10);
    check("w10_ovf",         64'(ovf_m), 64'd0);
    @(negedge clk);
    check("w10_pulse", 64'(valid_m), 64'd0);
    wait_valid("w10_b_to", 0, 1100, n);
    check("w10_b_period", 64'(n), 64'd1023);
    check("w10_b_count",  64'(count_m), 64'd128);
    wait_valid("w10_c_to", 0, 1100, n);
    check("w10_c_period", 64'(n), 64'd1024);
    check("w10_c_count",  64'(count_m), 64'd128);
    check("w10_c_log2n",  64'(l2_m), 64'd10);

    // One-cycle windows.
    en = 1'b0;
    repeat (3) @(negedge clk);
    log2n = 5'd0; period = 2;
    repeat (6) @(negedge clk);
    en = 1'b1;
    wait_valid("w0_to", 0, 5, n);
    check("w0_lat", 64'(n), 64'd2);
    last = count_m;
    check("w0_first_bit", 64'(last <= 32'd1), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("w0_valid", 64'(valid_m), 64'd1);
      check("w0_alt",   64'(count_m), 64'(32'd1 - last));
      last = count_m;
    end
    check("w0_log2n", 64'(l2_m), 64'd0);
    en = 1'b0;

    // Saturation on the 4-bit counter build.
    log2n = 5'd6;
    repeat (3) @(negedge clk);
    en_sat = 1'b1;
    wait_valid("sat_a_to", 1, 200, n);
    check("sat_a_count", 64'(count_s), 64'd15);
    check("sat_a_ovf",   64'(ovf_s),   64'd1);
    log2n = 5'd3;
    wait_valid("sat_b_to", 1, 100, n);
    check("sat_b_period", 64'(n),       64'd64);
    check("sat_b_log2n",  64'(l2_s),    64'd6);
    check("sat_b_count",  64'(count_s), 64'd15);
    wait_valid("sat_c_to", 1, 100, n);
    check("sat_c_period", 64'(n),       64'd8);
    check("sat_c_count",  64'(count_s), 64'd4);
    check("sat_c_ovf",    64'(ovf_s),   64'd0);
    check("sat_c_log2n",  64'(l2_s),    64'd3);
    en_sat = 1'b0;

    // Abort at gate cycle 100, then reconfigure mid-window.
    log2n = 5'd8; period = 8;
    repeat (20) @(negedge clk);
    prev_cnt = count_m; prev_l2 = l2_m; saw = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      saw = saw | valid_m;
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      saw = saw | valid_m;
    end
    check("abort_novalid", 64'(saw),     64'd0);
    check("abort_busy",    64'(busy_m),  64'd0);
    check("abort_count",   64'(count_m), 64'(prev_cnt));
    check("abort_log2n",   64'(l2_m),    64'(prev_l2));
    en = 1'b1;
    repeat (50) @(negedge clk);
    log2n = 5'd5;
    wait_valid("recfg_a_to", 0, 300, n);
    check("recfg_a_lat",   64'(n),       64'd207);
    check("recfg_a_log2n", 64'(l2_m),    64'd8);
    check("recfg_a_count", 64'(count_m), 64'd32);
    wait_valid("recfg_b_to", 0, 100, n);
    check("recfg_b_period", 64'(n),       64'd32);
    check("recfg_b_log2n",  64'(l2_m),    64'd5);
    check("recfg_b_count",  64'(count_m), 64'd4);
    en = 1'b0;

    // Exponent clamp on the 8-bit gate build.
    log2n = 5'd31;
    repeat (3) @(negedge clk);
    en_clp = 1'b1;
    wait_valid("clamp_a_to", 2, 300, n);
    check("clamp_a_lat",   64'(n),    64'd129);
    check("clamp_a_log2n", 64'(l2_c), 64'd7);
    check("clamp_a_ovf",   64'(ovf_c), 64'd0);
    wait_valid("clamp_b_to", 2, 300, n);
    check("clamp_b_period", 64'(n),       64'd128);
    check("clamp_b_count",  64'(count_c), 64'd16);
    en_clp = 1'b0;

    // Asynchronous reset in the middle of a window.
    log2n = 5'd8;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (50) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("arst_busy",  64'(busy_m),  64'd0);
    check("arst_count", 64'(count_m), 64'd0);
    check("arst_log2n", 64'(l2_m),    64'd0);
    check("arst_ovf",   64'(ovf_m),   64'd0);
    check("arst_valid", 64'(valid_m), 64'd0);
    repeat (3) @(negedge clk);
    check("arst_hold_busy", 64'(busy_m), 64'd0);
    rstn = 1'b1;
    wait_valid("arst_to", 0, 400, n);
    check("arst_lat",   64'(n),    64'd257);
    check("arst_log2n", 64'(l2_m), 64'd8);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy_all", 64'({busy_m, busy_s, busy_c}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
- Gate-time sequencer and edge counter for the frequency-counter datapath.
- Opens back-to-back measurement windows of exactly 2^log2N clock cycles and counts rising edges of an asynchronous input inside each window.
- At each window end it publishes the count together with the log2N used, so software derives frequency = count * f_clk / 2^log2N by shifting.
- Sits between the configuration register (log2N, enable) and the readout/AXI-GPIO register.

Parameters:
- LOG2N_WIDTH, 5, width of gate-exponent config input.
- N_WIDTH, 32, width of gate-length counter; max effective log2N is N_WIDTH-1.
- COUNT_WIDTH, 32, width of edge counter and result.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  run enable; level sensitive.
- log2N  in  LOG2N_WIDTH  requested gate exponent; sampled only at window start.
- sig_in  in  1  asynchronous signal under measurement.
- busy  out  1  high while a window is open.
- count_o  out  COUNT_WIDTH  edge count of last completed window; held until next completion.
- log2N_o  out  LOG2N_WIDTH  effective (clamped) exponent that produced count_o.
- ovf_o  out  1  last completed window saturated its counter.
- valid_o  out  1  one-cycle pulse when count_o/log2N_o/ovf_o update.

Behaviour:
- Reset (rstn low, async): state IDLE; busy, count_o, log2N_o, ovf_o, valid_o all 0; synchronizer and counters cleared.
- Input path: 2-FF synchronizer on sig_in, then a third FF for rising-edge detect; an edge is counted 3 clk cycles after it occurs at the pin. The synchronizer runs in all states.
- Clamp: eff = min(log2N, N_WIDTH-1); gate length N = 1 << eff.
- State IDLE: busy=0. If en=1, capture eff into log2N_reg, clear gate_cnt and edge_cnt, and go to GATE on the next cycle.
- State GATE: busy=1. Each cycle gate_cnt increments, and edge_cnt increments when the edge-detect is high.
- edge_cnt saturates at all-ones; a sticky ovf flag is set on any attempted increment past all-ones.
- Window end is the cycle where gate_cnt == N-1. The window therefore covers exactly N cycles.
- At window end:
  - Register count_o = edge_cnt + edge_this_cycle (saturating), log2N_o = log2N_reg and ovf_o = ovf.
  - valid_o pulses high on the following cycle, aligned with the new outputs.
- After window end:
  - If en=1, the next window starts on the immediately following cycle. No dead time and no missed edges.
  - log2N is re-sampled for that window, with fresh counters.
  - If en=0, return to IDLE.
- en deasserted mid-window: abort at the next clock edge. Go to IDLE with no valid_o; count_o, log2N_o and ovf_o keep their previous values.
- log2N changed mid-window: ignored until the next window start.
- eff=0: 1-cycle windows. count_o is 0 or 1 and valid_o is high every cycle while en=1.
- Latency from window start (first GATE cycle) to valid_o: N+1 cycles.
- Reset mid-window: immediate return to reset state; no valid_o.

Decomposition:
- Shared package freq_cnt_pkg holds:
  - state enum {IDLE, GATE};
  - default widths;
  - constant EFF_MAX = N_WIDTH-1.
- The gate-length decode uses the existing pow2 sub-module (LOG2N_WIDTH, N_WIDTH) fed by the clamped exponent.
- The synchronizer plus edge detect forms the natural separate sub-module, sync_edge_det (1-bit input, rising-edge pulse output, 3-cycle latency).

Test Plan:
- Periodic input, log2N=10, en held:
  - Stimulus: sig_in square wave with period 8 clk.
  - Required: valid_o every 1024 cycles; count_o=128 each window (+/-1 only on the first window); log2N_o=10; ovf_o=0.
- log2N=0 with sig_in period 2 clk:
  - Required: valid_o high every cycle; count_o alternates 1,0,1,0.
- Saturation, COUNT_WIDTH=4, log2N=6:
  - Stimulus: sig_in period 2 clk (32 edges per window).
  - Required: count_o=15 and ovf_o=1. After changing to log2N=3 (4 edges), the next result is count_o=4 and ovf_o=0.
- Abort and reconfigure:
  - Stimulus: log2N=8; drop en at gate cycle 100; later change log2N to 5 mid-window, then re-enable.
  - Required: no valid_o for the aborted window and count_o unchanged. The window running when log2N changes still completes at 256 cycles with log2N_o=8; the following one completes at 32 cycles with log2N_o=5.
- Clamp:
  - Stimulus: log2N=31 with N_WIDTH=8.
  - Required: log2N_o=7 and window length 128 cycles.
- Async reset asserted at gate cycle 50, released, en high:
  - Required: all outputs 0 during reset; the first valid_o arrives N+1 cycles after the first GATE cycle following release.
